// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared definitions for the multiply issue stage: op encodings, operand
// signedness codes for the multiplier, and the issue FSM state enum.
package ysyx_22050854_mul_pkg;

   localparam int unsigned OP_W  = 2;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned SGN_W = 2;

   // RISC-V M-extension multiply flavours as presented by the EXU
   typedef enum logic [OP_W-1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   // m_signed[1] = multiplicand signed, m_signed[0] = multiplier signed
   localparam logic [SGN_W-1:0] SGN_SS = 2'b11;
   localparam logic [SGN_W-1:0] SGN_SU = 2'b10;
   localparam logic [SGN_W-1:0] SGN_UU = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } mul_state_e;

   // Operand signedness for an op; MULW always multiplies signed words
   function automatic logic [SGN_W-1:0] signed_code(input mul_op_e op, input logic word);
      logic [SGN_W-1:0] code;
      code = SGN_SS;
      if (!word) begin
         case (op)
            OP_MUL, OP_MULH: code = SGN_SS;
            OP_MULHSU:       code = SGN_SU;
            OP_MULHU:        code = SGN_UU;
            default:         code = SGN_SS;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/ysyx_22050854_mul_issue.sv
// Multiply issue stage: accepts one multiply op from the EXU, hands its
// operands to an external multiplier, waits for the product, selects the
// architectural result and presents it on the writeback handshake.
// Supports cancellation (flush) at any point, including draining a product
// already in flight inside the multiplier.
//
// Optional feature macro: YSYX_22050854_MUL_ZERO_BYPASS_EN -- when defined,
// an op with a zero operand completes directly with result 0 and is never
// sent to the multiplier.
//
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_ready, in_op, in_word, in_rd, in_src1, in_src2 : EXU request
//   flush                                                     : cancel in-flight op
//   out_valid/out_ready, out_rd, out_result                   : writeback
//   busy                                                      : state != IDLE
//   m_valid/m_ready, m_signed, m_mulw, m_flush,
//   m_multiplicand, m_multiplier                              : multiplier request
//   m_out_valid, m_result_hi, m_result_lo                     : multiplier response
module ysyx_22050854_mul_issue
   import ysyx_22050854_mul_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_word,
   input  logic [RD_W-1:0]  in_rd,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RD_W-1:0]  out_rd,
   output logic [XLEN-1:0]  out_result,
   output logic             busy,
   output logic             m_valid,
   output logic             m_mulw,
   output logic             m_flush,
   output logic [SGN_W-1:0] m_signed,
   output logic [XLEN-1:0]  m_multiplicand,
   output logic [XLEN-1:0]  m_multiplier,
   input  logic             m_ready,
   input  logic             m_out_valid,
   input  logic [XLEN-1:0]  m_result_hi,
   input  logic [XLEN-1:0]  m_result_lo
);

   mul_state_e      state_q, state_d;
   mul_op_e         op_q;
   logic            word_q;
   logic [RD_W-1:0] rd_q;
   logic [XLEN-1:0] src1_q, src2_q, result_q;
   logic            accept_c, capture_c, bypass_c;
   logic [XLEN-1:0] sel_result_c;

   // Handshake / status outputs, all derived from the current state
   assign in_ready       = (state_q == ST_IDLE) & ~flush;
   assign busy           = (state_q != ST_IDLE);
   assign m_valid        = (state_q == ST_REQ) & ~flush;
   assign m_flush        = flush & (state_q != ST_IDLE);
   assign out_valid      = (state_q == ST_DONE) & ~flush;
   assign out_rd         = rd_q;
   assign out_result     = result_q;
   assign m_multiplicand = src1_q;
   assign m_multiplier   = src2_q;
   assign m_mulw         = word_q;
   assign m_signed       = signed_code(op_q, word_q);

   // Architectural result from the raw product
   always_comb begin
      sel_result_c = m_result_hi;
      if (word_q)
         sel_result_c = {{(XLEN-32){m_result_lo[31]}}, m_result_lo[31:0]};
      else if (op_q == OP_MUL)
         sel_result_c = m_result_lo;
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and datapath strobes
   always_comb begin
      state_d   = state_q;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      bypass_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               accept_c = 1'b1;
               state_d  = ST_REQ;
`ifdef YSYX_22050854_MUL_ZERO_BYPASS_EN
               if (in_src1 == '0 || in_src2 == '0) begin
                  bypass_c = 1'b1;
                  state_d  = ST_DONE;
               end
`endif
            end
         end
         ST_REQ: begin
            if (flush)        state_d = ST_IDLE;
            else if (m_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A product arriving in the flush cycle is itself the one to drop
            if (flush)            state_d = m_out_valid ? ST_IDLE : ST_DRAIN;
            else if (m_out_valid) begin
               capture_c = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (flush || out_ready) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (m_out_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Latched request and captured result
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q     <= OP_MUL;
         word_q   <= 1'b0;
         rd_q     <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         result_q <= '0;
      end else begin
         if (accept_c) begin
            op_q   <= mul_op_e'(in_op);
            word_q <= in_word;
            rd_q   <= in_rd;
            src1_q <= in_src1;
            src2_q <= in_src2;
            if (bypass_c) result_q <= '0;
         end
         if (capture_c) result_q <= sel_result_c;
      end
   end

endmodule

// File: tb/tb_ysyx_22050854_mul_issue.sv
// Directed self-checking bench for ysyx_22050854_mul_issue. The bench plays
// the role of the multiplier, supplying hand-computed hi/lo products.
module tb_ysyx_22050854_mul_issue;

   logic        clock, reset;
   logic        in_valid, in_ready, in_word, flush;
   logic [1:0]  in_op;
   logic [4:0]  in_rd, out_rd;
   logic [63:0] in_src1, in_src2, out_result;
   logic        out_valid, out_ready, busy;
   logic        m_valid, m_mulw, m_flush, m_ready, m_out_valid;
   logic [1:0]  m_signed;
   logic [63:0] m_multiplicand, m_multiplier, m_result_hi, m_result_lo;

   int checks   = 0;
   int failures = 0;
   int xfer_cnt = 0;

   ysyx_22050854_mul_issue #(.XLEN(64)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
      .in_rd(in_rd), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_result(out_result), .busy(busy),
      .m_valid(m_valid), .m_mulw(m_mulw), .m_flush(m_flush), .m_signed(m_signed),
      .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
      .m_ready(m_ready), .m_out_valid(m_out_valid),
      .m_result_hi(m_result_hi), .m_result_lo(m_result_lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Writeback transfers seen mid-cycle
   always @(negedge clock) if (out_valid && out_ready) xfer_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full op: accept, one REQ stall, handshake, one WAIT cycle, product,
   // then 'hold' cycles of out_ready low before the transfer.
   task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                         input logic [4:0] rd, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [1:0] exp_sgn, input logic [63:0] hi,
                         input logic [63:0] lo, input logic [63:0] exp_res, input int hold);
      int x0;
      x0 = xfer_cnt;
      in_valid = 1'b1; in_op = op; in_word = word; in_rd = rd; in_src1 = s1; in_src2 = s2;
      #1 chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0; in_src1 = 64'hDEAD_BEEF_0BAD_F00D; in_src2 = 64'h1234_5678_9ABC_DEF0;
      #1;
      chk({tag, ".m_valid"}, 64'(m_valid), 64'd1);
      chk({tag, ".m_signed"}, 64'(m_signed), 64'(exp_sgn));
      chk({tag, ".m_mulw"}, 64'(m_mulw), 64'(word));
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      tick();
      chk({tag, ".req_hold"}, 64'(m_valid), 64'd1);
      chk({tag, ".mcand"}, m_multiplicand, s1);
      chk({tag, ".mplier"}, m_multiplier, s2);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      #1 chk({tag, ".wait_mvalid"}, 64'(m_valid), 64'd0);
      tick();
      m_out_valid = 1'b1; m_result_hi = hi; m_result_lo = lo;
      #1 chk({tag, ".wait_ovalid"}, 64'(out_valid), 64'd0);
      tick();
      m_out_valid = 1'b0; m_result_hi = 64'h5555_AAAA_5555_AAAA; m_result_lo = 64'hAAAA_5555_AAAA_5555;
      in_valid = 1'b1;
      #1;
      chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".result"}, out_result, exp_res);
      chk({tag, ".rd"}, 64'(out_rd), 64'(rd));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, ".hold_result"}, out_result, exp_res);
         chk({tag, ".hold_rd"}, 64'(out_rd), 64'(rd));
         chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1 chk({tag, ".xfer_in_ready"}, 64'(in_ready), 64'd0);
      @(posedge clock);
      in_valid = 1'b0;
      #1;
      out_ready = 1'b0;
      chk({tag, ".post_busy"}, 64'(busy), 64'd0);
      chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".xfers"}, 64'(xfer_cnt - x0), 64'd1);
   endtask

   initial begin
      int x0;
      reset = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0; in_rd = 5'd0;
      in_src1 = '0; in_src2 = '0; flush = 1'b0; out_ready = 1'b0;
      m_ready = 1'b0; m_out_valid = 1'b0; m_result_hi = '0; m_result_lo = '0;
      #2;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.m_valid", 64'(m_valid), 64'd0);
      chk("rst.m_flush", 64'(m_flush), 64'd0);
      chk("rst.out_result", out_result, 64'd0);
      chk("rst.out_rd", 64'(out_rd), 64'd0);
      chk("rst.mcand", m_multiplicand, 64'd0);
      #20 reset = 1'b1;
      tick();

      // 3 * -5 = -15
      run_op("mul", 2'b00, 1'b0, 5'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b11,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1, 0);
      // -2^63 * 2 = -2^64
      run_op("mulh", 2'b01, 1'b0, 5'd2, 64'h8000_0000_0000_0000, 64'd2, 2'b11,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      // 2^63 * 2 = 2^64
      run_op("mulhu", 2'b11, 1'b0, 5'd3, 64'h8000_0000_0000_0000, 64'd2, 2'b00,
             64'd1, 64'd0, 64'd1, 0);
      // -1 * 2 (unsigned) = -2
      run_op("mulhsu", 2'b10, 1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b10,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      // MULW with in_op=MULHU to show op is ignored; word product sign-extends
      run_op("mulw", 2'b11, 1'b1, 5'd5, 64'h0000_0000_7FFF_FFFF, 64'd2, 2'b11,
             64'd0, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 0);

      // Flush three cycles into WAIT, drain the stray product, then 5*7
      x0 = xfer_cnt;
      in_valid = 1'b1; in_op = 2'b00; in_word = 1'b0; in_rd = 5'd6; in_src1 = 64'd9; in_src2 = 64'd9;
      tick();
      in_valid = 1'b0; m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      #1;
      chk("fl.m_flush", 64'(m_flush), 64'd1);
      chk("fl.in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl.m_flush_pulse", 64'(m_flush), 64'd0);
      chk("fl.drain_busy", 64'(busy), 64'd1);
      chk("fl.drain_in_ready", 64'(in_ready), 64'd0);
      m_out_valid = 1'b1; m_result_lo = 64'd81; m_result_hi = 64'd0;
      #1 chk("fl.drain_ovalid", 64'(out_valid), 64'd0);
      tick();
      m_out_valid = 1'b0;
      #1;
      chk("fl.idle_in_ready", 64'(in_ready), 64'd1);
      chk("fl.idle_ovalid", 64'(out_valid), 64'd0);
      run_op("mul57", 2'b00, 1'b0, 5'd7, 64'd5, 64'd7, 2'b11, 64'd0, 64'd35, 64'd35, 0);
      chk("fl.single_xfer", 64'(xfer_cnt - x0), 64'd1);

      // out_ready held low 5 cycles in DONE
      run_op("hold", 2'b00, 1'b0, 5'd31, 64'd6, 64'd7, 2'b11, 64'd0, 64'd42, 64'd42, 5);

      // Flush in REQ suppresses m_valid and returns to IDLE
      in_valid = 1'b1; in_src1 = 64'd2; in_src2 = 64'd3;
      tick();
      in_valid = 1'b0; flush = 1'b1; m_ready = 1'b1;
      #1;
      chk("flreq.m_valid", 64'(m_valid), 64'd0);
      chk("flreq.m_flush", 64'(m_flush), 64'd1);
      tick();
      flush = 1'b0; m_ready = 1'b0;
      #1 chk("flreq.busy", 64'(busy), 64'd0);

      // Flush in DONE wins over out_ready; no transfer
      x0 = xfer_cnt;
      in_valid = 1'b1; in_rd = 5'd8;
      tick();
      in_valid = 1'b0; m_ready = 1'b1;
      tick();
      m_ready = 1'b0; m_out_valid = 1'b1; m_result_lo = 64'd6;
      tick();
      m_out_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
      #1 chk("fldone.out_valid", 64'(out_valid), 64'd0);
      tick();
      flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("fldone.busy", 64'(busy), 64'd0);
      chk("fldone.no_xfer", 64'(xfer_cnt - x0), 64'd0);

      // Reset while in WAIT
      in_valid = 1'b1; in_rd = 5'd12; in_src1 = 64'd4; in_src2 = 64'd4;
      tick();
      in_valid = 1'b0; m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      #1 chk("rstw.busy_pre", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("rstw.in_ready", 64'(in_ready), 64'd1);
      chk("rstw.busy", 64'(busy), 64'd0);
      chk("rstw.out_rd", 64'(out_rd), 64'd0);
      tick();
      #2 reset = 1'b1;
      tick();
      m_out_valid = 1'b1; m_result_lo = 64'd16; out_ready = 1'b1;
      tick();
      m_out_valid = 1'b0;
      #1;
      chk("rstw.stray_ovalid", 64'(out_valid), 64'd0);
      chk("rstw.stray_busy", 64'(busy), 64'd0);
      tick();
      chk("rstw.stray_ovalid2", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
